// File: rtl/hdelay_arb_pkg.sv
// Shared types and helpers for the delay-line arbiter: FSM states and requester-id sizing.
package hdelay_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // Requester-id width; a single bit is kept even for degenerate counts.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hrr_arbiter.sv
// Round-robin picker: scans the eligible vector starting at a rotating pointer,
// returns a one-hot grant plus the encoded winner, and advances past the winner.
module hrr_arbiter
    import hdelay_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = id_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  eligible,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] winner,
    output logic          found
);

    logic [IW-1:0] ptr;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
    end

    // Pointer only moves on an actual grant, so an empty cycle keeps the rotation fair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (winner == IW'(N-1)) ? '0 : winner + IW'(1);
        end
    end

endmodule

// File: rtl/hdelay_arbiter.sv
// Shares an external fixed-latency delay line among NUM_REQ streams; a tag pipe of
// equal depth carries {valid, id} so each delayed sample is routed back to its owner.
module hdelay_arbiter
    import hdelay_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int NUM_DELAY  = 5,
    parameter int MAX_OUTST  = 4
) (
    input  logic                          hclk,
    input  logic                          hres,
    input  logic                          hen,
    input  logic                          hflush,
    input  logic [NUM_REQ-1:0]            hreq_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] hreq_data,
    output logic [NUM_REQ-1:0]            hreq_ready,
    output logic [DATA_WIDTH-1:0]         hpipe_in,
    input  logic [DATA_WIDTH-1:0]         hpipe_out,
    output logic [NUM_REQ-1:0]            hrsp_valid,
    output logic [DATA_WIDTH-1:0]         hrsp_data,
    output logic                          hbusy,
    output logic                          hidle,
    output arb_state_t                    hstate
);

    // Handshake: a request transfers in the cycle where hreq_valid[i] & hreq_ready[i];
    // responses are single-cycle strobes with no backpressure.
    localparam int IW = id_width(NUM_REQ);
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);

    arb_state_t           state, state_nx;
    logic                 grant_en;
    logic                 found;
    logic                 tail_valid;
    logic                 pending;
    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   grant;
    logic [IW-1:0]        winner;
    logic [IW-1:0]        tail_id;
    logic [NUM_DELAY-1:0] tag_valid;
    logic [IW-1:0]        tag_id [NUM_DELAY];
    logic [CW-1:0]        credit [NUM_REQ];

    assign grant_en = (state == RUN) && hen && !hflush;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = grant_en && hreq_valid[i] && (credit[i] < MAX_C);
        end
    end

    hrr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .clk      (hclk),
        .rst_n    (hres),
        .eligible (eligible),
        .grant    (grant),
        .winner   (winner),
        .found    (found)
    );

    assign hreq_ready = grant;
    assign hpipe_in   = found ? hreq_data[winner*DATA_WIDTH +: DATA_WIDTH] : '0;

    assign tail_valid = tag_valid[NUM_DELAY-1];
    assign tail_id    = tag_id[NUM_DELAY-1];
    assign hrsp_data  = hpipe_out;
    assign hbusy      = |tag_valid;
    assign hidle      = (state == IDLE);
    assign hstate     = state;

    always_comb begin
        hrsp_valid = '0;
        if (tail_valid) begin
            hrsp_valid[tail_id] = 1'b1;
        end
    end

    // Tags that will still be in flight after this edge (the tail leaves now).
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < NUM_DELAY - 1; i++) begin
            pending = pending | tag_valid[i];
        end
    end

    always_comb begin
        state_nx = state;
        if (hflush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (hen) state_nx = RUN;
                RUN:     if (!hen) state_nx = DRAIN;
                DRAIN: begin
                    if (hen) begin
                        state_nx = RUN;
                    end else if (!pending) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge hclk or negedge hres) begin
        if (!hres) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge hclk or negedge hres) begin
        if (!hres) begin
            tag_valid <= '0;
            for (int i = 0; i < NUM_DELAY; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_valid[0] <= found;
            tag_id[0]    <= winner;
            for (int i = 1; i < NUM_DELAY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
            if (hflush) begin
                tag_valid <= '0;
            end
        end
    end

    always_ff @(posedge hclk or negedge hres) begin
        if (!hres) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                credit[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hflush) begin
                    credit[i] <= '0;
                end else begin
                    case ({found && (winner == IW'(i)), tail_valid && (tail_id == IW'(i))})
                        2'b10:   credit[i] <= credit[i] + CW'(1);
                        2'b01:   if (credit[i] != '0) credit[i] <= credit[i] - CW'(1);
                        default: credit[i] <= credit[i];
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_hdelay_arbiter.sv
// Bench for hdelay_arbiter: drives directed and random traffic, models the delay line
// externally and compares every cycle against a queue-based reference of the arbitration rules.
module tb_hdelay_arbiter;
    import hdelay_arb_pkg::*;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int ND = 5;
    localparam int MO = 4;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic              hclk;
    logic              hres;
    logic              hen;
    logic              hflush;
    logic [NR-1:0]     hreq_valid;
    logic [NR*DW-1:0]  hreq_data;
    logic [NR-1:0]     hreq_ready;
    logic [DW-1:0]     hpipe_in;
    logic [DW-1:0]     hpipe_out;
    logic [NR-1:0]     hrsp_valid;
    logic [DW-1:0]     hrsp_data;
    logic              hbusy;
    logic              hidle;
    arb_state_t        hstate;

    hdelay_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .NUM_DELAY  (ND),
        .MAX_OUTST  (MO)
    ) dut (
        .hclk       (hclk),
        .hres       (hres),
        .hen        (hen),
        .hflush     (hflush),
        .hreq_valid (hreq_valid),
        .hreq_data  (hreq_data),
        .hreq_ready (hreq_ready),
        .hpipe_in   (hpipe_in),
        .hpipe_out  (hpipe_out),
        .hrsp_valid (hrsp_valid),
        .hrsp_data  (hrsp_data),
        .hbusy      (hbusy),
        .hidle      (hidle),
        .hstate     (hstate)
    );

    // Clock / reset
    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // External delay line: fixed latency ND, never stalls.
    logic [DW-1:0] dline [ND];
    always @(posedge hclk) begin
        dline[0] <= hpipe_in;
        for (int i = 1; i < ND; i++) begin
            dline[i] <= dline[i-1];
        end
    end
    assign hpipe_out = dline[ND-1];

    // Reference model state and scoreboard
    int            mode;
    int            ptr;
    int            credit_m [NR];
    int            cyc;
    logic [DW-1:0] exp_q [$];
    int            due_q [$];
    int            id_q  [$];
    int            n_checks;
    int            n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        mode = M_IDLE;
        ptr  = 0;
        for (int i = 0; i < NR; i++) credit_m[i] = 0;
        exp_q.delete();
        due_q.delete();
        id_q.delete();
    endtask

    // Evaluates expected outputs for the current cycle's inputs, compares, then advances.
    task automatic model_step();
        logic [NR-1:0] e_rv;
        logic [NR-1:0] e_rdy;
        logic [DW-1:0] e_pin;
        logic [DW-1:0] e_rdat;
        int            rid;
        int            w;
        int            idx;
        e_rv   = '0;
        e_rdy  = '0;
        e_pin  = '0;
        e_rdat = '0;
        rid    = -1;
        w      = -1;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            rid       = id_q[0];
            e_rdat    = exp_q[0];
            e_rv[rid] = 1'b1;
        end
        if (mode == M_RUN && hen && !hflush) begin
            for (int k = 0; k < NR; k++) begin
                idx = (ptr + k) % NR;
                if (w < 0 && hreq_valid[idx] && credit_m[idx] < MO) w = idx;
            end
        end
        if (w >= 0) begin
            e_rdy[w] = 1'b1;
            e_pin    = hreq_data[w*DW +: DW];
        end

        check("hreq_ready", 32'(hreq_ready), 32'(e_rdy));
        check("hpipe_in", 32'(hpipe_in), 32'(e_pin));
        check("hrsp_valid", 32'(hrsp_valid), 32'(e_rv));
        if (rid >= 0) check("hrsp_data", 32'(hrsp_data), 32'(e_rdat));
        check("hbusy", 32'(hbusy), 32'(due_q.size() != 0));
        check("hidle", 32'(hidle), 32'(mode == M_IDLE));

        if (rid >= 0) begin
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
            void'(id_q.pop_front());
            credit_m[rid]--;
        end
        if (w >= 0) begin
            exp_q.push_back(e_pin);
            due_q.push_back(cyc + ND);
            id_q.push_back(w);
            credit_m[w]++;
            ptr = (w + 1) % NR;
        end
        if (hflush) begin
            exp_q.delete();
            due_q.delete();
            id_q.delete();
            for (int i = 0; i < NR; i++) credit_m[i] = 0;
            mode = M_IDLE;
        end else begin
            case (mode)
                M_IDLE:  if (hen) mode = M_RUN;
                M_RUN:   if (!hen) mode = M_DRAIN;
                default: begin
                    if (hen) mode = M_RUN;
                    else if (due_q.size() == 0) mode = M_IDLE;
                end
            endcase
        end
        cyc++;
    endtask

    // Driver tasks: called at posedge+1, leave at the next posedge+1.
    task automatic run_cycle(input logic en, input logic fl, input logic [NR-1:0] v,
                             input logic [NR*DW-1:0] d);
        hen        = en;
        hflush     = fl;
        hreq_valid = v;
        hreq_data  = d;
        @(negedge hclk);
        model_step();
        @(posedge hclk);
        #1;
    endtask

    function automatic logic [NR*DW-1:0] rand_data();
        logic [NR*DW-1:0] d;
        for (int i = 0; i < NR; i++) d[i*DW +: DW] = DW'($urandom_range(0, 255));
        return d;
    endfunction

    task automatic rand_cycle(input int p_en, input int p_fl);
        run_cycle($urandom_range(0, 99) < p_en, $urandom_range(0, 99) < p_fl,
                  NR'($urandom_range(0, (1 << NR) - 1)), rand_data());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(hreq_ready), 32'h0);
        check({tag, "_rsp"}, 32'(hrsp_valid), 32'h0);
        check({tag, "_busy"}, 32'(hbusy), 32'h0);
        check({tag, "_idle"}, 32'(hidle), 32'h1);
        check({tag, "_pipe"}, 32'(hpipe_in), 32'h0);
    endtask

    // Asserts reset between edges while traffic is active.
    task automatic mid_reset();
        hen        = 1'b1;
        hflush     = 1'b0;
        hreq_valid = '1;
        hreq_data  = rand_data();
        #2;
        hres = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge hclk);
        @(posedge hclk);
        #1;
        hres = 1'b1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        hres       = 1'b0;
        hen        = 1'b0;
        hflush     = 1'b0;
        hreq_valid = '0;
        hreq_data  = '0;
        model_reset();
        repeat (3) @(posedge hclk);
        #1;
        check_reset_outputs("reset");
        hres = 1'b1;

        // Single requester, 0x11 from req0
        run_cycle(1'b1, 1'b0, 4'b0001, {24'h0, 8'h11});
        run_cycle(1'b1, 1'b0, 4'b0001, {24'h0, 8'h11});
        repeat (8) run_cycle(1'b1, 1'b0, 4'b0000, '0);

        // Fairness: everyone asks every cycle
        repeat (24) run_cycle(1'b1, 1'b0, 4'b1111, rand_data());
        repeat (8) run_cycle(1'b1, 1'b0, 4'b0000, '0);

        // Credit limit on a lone requester
        repeat (24) run_cycle(1'b1, 1'b0, 4'b0100, rand_data());
        repeat (8) run_cycle(1'b1, 1'b0, 4'b0000, '0);

        // Drain: three accepts, then enable drops
        repeat (3) run_cycle(1'b1, 1'b0, 4'b1111, rand_data());
        repeat (12) run_cycle(1'b0, 1'b0, 4'b1111, rand_data());

        // Flush with samples in flight, then full rate again
        repeat (4) run_cycle(1'b1, 1'b0, 4'b1111, rand_data());
        run_cycle(1'b1, 1'b1, 4'b1111, rand_data());
        repeat (16) run_cycle(1'b1, 1'b0, 4'b1111, rand_data());

        // Random traffic
        repeat (1500) rand_cycle(85, 3);

        // Reset mid-stream, then all requesting: first grant must go to requester 0
        mid_reset();
        repeat (6) run_cycle(1'b1, 1'b0, 4'b1111, rand_data());
        repeat (300) rand_cycle(90, 2);
        repeat (10) run_cycle(1'b0, 1'b0, 4'b0000, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
